// File: rtl/vector_load_unit_if.sv
// Request, SRAM and result signals of vector_load_unit bundled for port use.
// The stride signal exists only when VLD_STRIDE_EN is defined.
interface vector_load_unit_if #(
  parameter int LANES  = 16,
  parameter int WORD_W = 16
);
  logic                    start;
  logic [15:0]             base_addr;
`ifdef VLD_STRIDE_EN
  logic [15:0]             stride;
`endif
  logic [WORD_W-1:0]       mem_rdata;
  logic [15:0]             mem_addr;
  logic                    mem_rd;
  logic [LANES*WORD_W-1:0] vec_data;
  logic                    busy;
  logic                    done;

  // master: the requester plus the SRAM read-data path; slave: the load unit
  modport master (
`ifdef VLD_STRIDE_EN
    output stride,
`endif
    output start, base_addr, mem_rdata,
    input  mem_addr, mem_rd, vec_data, busy, done
  );

  modport slave (
`ifdef VLD_STRIDE_EN
    input  stride,
`endif
    input  start, base_addr, mem_rdata,
    output mem_addr, mem_rd, vec_data, busy, done
  );
endinterface

// File: rtl/vector_load_unit.sv
// Gathers LANES consecutive SRAM words into one vector, one read per lane.
// Optional VLD_STRIDE_EN: lane address advances by a latched stride instead of 1.
module vector_load_unit #(
  parameter int LANES  = 16,
  parameter int WORD_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk2,
  input  logic             rst,
  vector_load_unit_if.slave bus
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             addr_q, addr_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LANES*WORD_W-1:0] vec_q, vec_d;
  logic [15:0]             addr_inc;

`ifdef VLD_STRIDE_EN
  logic [15:0]             stride_q, stride_d;
  assign addr_inc = stride_q;
`else
  assign addr_inc = 16'd1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
`ifdef VLD_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          lane_d  = '0;
`ifdef VLD_STRIDE_EN
          stride_d = bus.stride;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // read data is only trusted on the last wait cycle
        if (cnt_q == '0) begin
          vec_d[lane_q*WORD_W +: WORD_W] = bus.mem_rdata;
          if (lane_q == LAST_LANE) begin
            state_d = S_DONE;
          end else begin
            lane_d  = lane_q + 1'b1;
            addr_d  = addr_q + addr_inc;
            state_d = S_REQ;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
`ifdef VLD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
`ifdef VLD_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  // addr_q only moves when entering REQ, so it doubles as the held SRAM address
  assign bus.mem_addr = addr_q;
  assign bus.mem_rd   = (state_q == S_REQ);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.vec_data = vec_q;
endmodule

// File: tb/tb_vector_load_unit.sv
// Bench for vector_load_unit: two instances (RD_LAT=1 and RD_LAT=3) share stimulus
// and are checked every cycle against a cycle-arithmetic model plus literal values.
module tb_vector_load_unit;
  localparam int LANES = 16;
  localparam int W     = 16;

  logic        clk2 = 1'b0;
  logic        rst_r;
  logic        start_r;
  logic [15:0] base_r;
`ifdef VLD_STRIDE_EN
  logic [15:0] stride_r;
`endif

  always #5 clk2 = ~clk2;

  vector_load_unit_if #(.LANES(LANES), .WORD_W(W)) if_a ();
  vector_load_unit_if #(.LANES(LANES), .WORD_W(W)) if_b ();

  assign if_a.start     = start_r;
  assign if_b.start     = start_r;
  assign if_a.base_addr = base_r;
  assign if_b.base_addr = base_r;
`ifdef VLD_STRIDE_EN
  assign if_a.stride    = stride_r;
  assign if_b.stride    = stride_r;
`endif

  vector_load_unit #(.LANES(LANES), .WORD_W(W), .RD_LAT(1)) u_dut_a (
    .clk2(clk2), .rst(rst_r), .bus(if_a));
  vector_load_unit #(.LANES(LANES), .WORD_W(W), .RD_LAT(3)) u_dut_b (
    .clk2(clk2), .rst(rst_r), .bus(if_b));

  int          total, bad, t;
  bit          chk_en;
  bit          act [2];
  int          c0 [2];
  logic [15:0] mb [2], ms [2], e_addr [2];
  logic [15:0] e_vec [2][LANES];
  int          rd_cnt [2], done_cnt [2], start_t [2], done_t [2];
  logic [15:0] rd_first [2], rd_last [2];
  logic        h_v [2][5];
  logic [15:0] h_a [2][5];
  logic [15:0] off, xr;

  // SRAM contents are a function of the address so the model can recompute them
  function automatic logic [15:0] word(input logic [15:0] a);
    return (a + off) ^ xr;
  endfunction

  function automatic logic [15:0] lane_addr(input logic [15:0] b, input logic [15:0] s, input int j);
    return b + s * 16'(j);
  endfunction

  task automatic chk(input string name, input int n, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d cycle=%0d got=%h want=%h", name, n, t, got, want);
    end
  endtask

  task automatic monitor();
    logic        o_busy [2], o_done [2], o_rd [2];
    logic [15:0] o_addr [2];
    logic [255:0] o_vec [2];
    logic [255:0] ev;
    logic [15:0] rd;
    int k, per, fin, j;
    bit live, e_rd;
    t++;
    o_busy[0] = if_a.busy;     o_busy[1] = if_b.busy;
    o_done[0] = if_a.done;     o_done[1] = if_b.done;
    o_rd[0]   = if_a.mem_rd;   o_rd[1]   = if_b.mem_rd;
    o_addr[0] = if_a.mem_addr; o_addr[1] = if_b.mem_addr;
    o_vec[0]  = if_a.vec_data; o_vec[1]  = if_b.vec_data;
    for (int n = 0; n < 2; n++) begin
      per  = (n == 0) ? 2 : 4;
      fin  = 1 + LANES * per;
      k    = t - c0[n];
      live = act[n] && k >= 1 && k <= fin;
      e_rd = live && k < fin && ((k - 1) % per == 0);
      if (e_rd) e_addr[n] = lane_addr(mb[n], ms[n], (k - 1) / per);
      if (live && k > 1 && ((k - 1) % per == 0)) begin
        j = (k - 1) / per - 1;
        e_vec[n][j] = word(lane_addr(mb[n], ms[n], j));
      end
      for (int i = 0; i < LANES; i++) ev[i*W +: W] = e_vec[n][i];
      if (chk_en) begin
        chk("busy",     n, 256'(o_busy[n]), 256'(live));
        chk("done",     n, 256'(o_done[n]), 256'(live && k == fin));
        chk("mem_rd",   n, 256'(o_rd[n]),   256'(e_rd));
        chk("mem_addr", n, 256'(o_addr[n]), 256'(e_addr[n]));
        chk("vec_data", n, o_vec[n], ev);
      end
      if (o_rd[n] === 1'b1) begin
        if (rd_cnt[n] == 0) rd_first[n] = o_addr[n];
        rd_last[n] = o_addr[n];
        rd_cnt[n]++;
      end
      if (o_done[n] === 1'b1) begin
        done_cnt[n]++;
        done_t[n] = t;
      end
      // SRAM: data valid only exactly RD_LAT cycles after a request, garbage otherwise
      for (int i = 4; i > 0; i--) begin
        h_v[n][i] = h_v[n][i-1];
        h_a[n][i] = h_a[n][i-1];
      end
      h_v[n][0] = o_rd[n];
      h_a[n][0] = o_addr[n];
      rd = (h_v[n][per-1] === 1'b1) ? word(h_a[n][per-1]) : 16'($urandom);
      if (n == 0) if_a.mem_rdata = rd;
      else        if_b.mem_rdata = rd;
      if (rst_r === 1'b1) begin
        act[n] = 1'b0;
        e_addr[n] = '0;
        for (int i = 0; i < LANES; i++) e_vec[n][i] = '0;
      end else if (start_r && (!act[n] || k > fin)) begin
        act[n] = 1'b1;
        c0[n]  = t;
        mb[n]  = base_r;
`ifdef VLD_STRIDE_EN
        ms[n]  = stride_r;
`else
        ms[n]  = 16'd1;
`endif
        start_t[n] = t;
      end
    end
  endtask

  task automatic step();
    @(negedge clk2);
    monitor();
    @(posedge clk2);
    #1;
  endtask

  task automatic clear_stats();
    for (int n = 0; n < 2; n++) begin
      rd_cnt[n] = 0;
      done_cnt[n] = 0;
    end
  endtask

  task automatic drain(input int bound);
    int i = 0;
    while ((if_a.busy !== 1'b0 || if_b.busy !== 1'b0) && i < bound) begin
      step();
      i++;
    end
    chk("drain_timeout", 0, 256'(i >= bound), 256'(0));
    step();
  endtask

  task automatic load(input logic [15:0] b);
    base_r  = b;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
  endtask

  initial begin
    int i;
    total = 0; bad = 0; t = 0; chk_en = 1'b0;
    off = 16'h0FC0; xr = 16'h0000;
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; c0[n] = 0; e_addr[n] = '0; mb[n] = '0; ms[n] = '0;
      start_t[n] = 0; done_t[n] = 0; rd_first[n] = '0; rd_last[n] = '0;
      for (int l = 0; l < LANES; l++) e_vec[n][l] = '0;
      for (int l = 0; l < 5; l++) begin h_v[n][l] = 1'b0; h_a[n][l] = '0; end
    end
    clear_stats();
    rst_r = 1'b1; start_r = 1'b0; base_r = '0;
`ifdef VLD_STRIDE_EN
    stride_r = 16'd1;
`endif
    @(posedge clk2);
    #1;
    chk_en = 1'b1;
    step(); step();
    chk("reset_vec", 0, if_a.vec_data, 256'(0));
    chk("reset_addr", 0, 256'(if_a.mem_addr), 256'(0));
    rst_r = 1'b0;
    step();

    // basic load
    clear_stats();
    load(16'h0040);
    drain(200);
    chk("basic_latency", 0, 256'(done_t[0] - start_t[0]), 256'(33));
    chk("basic_latency", 1, 256'(done_t[1] - start_t[1]), 256'(65));
    chk("basic_rd_count", 0, 256'(rd_cnt[0]), 256'(16));
    chk("basic_rd_count", 1, 256'(rd_cnt[1]), 256'(16));
    chk("basic_first_addr", 0, 256'(rd_first[0]), 256'(16'h0040));
    chk("basic_last_addr", 0, 256'(rd_last[0]), 256'(16'h004F));
    chk("basic_lane0", 0, 256'(if_a.vec_data[15:0]), 256'(16'h1000));
    chk("basic_lane15", 0, 256'(if_a.vec_data[255:240]), 256'(16'h100F));
    chk("basic_lane15", 1, 256'(if_b.vec_data[255:240]), 256'(16'h100F));

    // address wrap
    clear_stats();
    load(16'hFFF8);
    drain(200);
    chk("wrap_first_addr", 0, 256'(rd_first[0]), 256'(16'hFFF8));
    chk("wrap_last_addr", 0, 256'(rd_last[0]), 256'(16'h0007));
    chk("wrap_lane8", 0, 256'(if_a.vec_data[143:128]), 256'(16'h0FC0));
    chk("wrap_lane8", 1, 256'(if_b.vec_data[143:128]), 256'(16'h0FC0));

    // start while busy is ignored
    clear_stats();
    load(16'h0100);
    repeat (9) step();
    load(16'h0200);
    drain(200);
    chk("ignore_done_count", 0, 256'(done_cnt[0]), 256'(1));
    chk("ignore_latency", 0, 256'(done_t[0] - start_t[0]), 256'(33));
    chk("ignore_last_addr", 0, 256'(rd_last[0]), 256'(16'h010F));

    // start held through DONE restarts right after
    clear_stats();
    base_r = 16'h0300; start_r = 1'b1;
    i = 0;
    while (done_cnt[0] == 0 && i < 100) begin step(); i++; end
    chk("held_done_timeout", 0, 256'(i >= 100), 256'(0));
    step();
    start_r = 1'b0;
    chk("held_rebusy", 0, 256'(if_a.busy), 256'(1));
    chk("held_restart_cycle", 0, 256'(start_t[0] - done_t[0]), 256'(1));
    drain(200);

    // reset mid-load
    clear_stats();
    load(16'h0500);
    repeat (14) step();
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    chk("midrst_vec", 0, if_a.vec_data, 256'(0));
    chk("midrst_busy", 0, 256'(if_a.busy), 256'(0));
    chk("midrst_rd", 0, 256'(if_a.mem_rd), 256'(0));
    chk("midrst_vec", 1, if_b.vec_data, 256'(0));
    chk("midrst_busy", 1, 256'(if_b.busy), 256'(0));
    repeat (70) step();
    chk("midrst_no_done", 0, 256'(done_cnt[0]), 256'(0));
    chk("midrst_no_done", 1, 256'(done_cnt[1]), 256'(0));
    clear_stats();
    load(16'h0600);
    drain(200);
    chk("after_rst_latency", 0, 256'(done_t[0] - start_t[0]), 256'(33));

`ifdef VLD_STRIDE_EN
    clear_stats();
    stride_r = 16'h0004;
    load(16'h0100);
    drain(200);
    chk("stride_last_addr", 0, 256'(rd_last[0]), 256'(16'h013C));
    stride_r = 16'h0000;
    load(16'h0100);
    drain(200);
    chk("stride0_lane0", 0, 256'(if_a.vec_data[15:0]), 256'(16'h10C0));
    chk("stride0_lane15", 0, 256'(if_a.vec_data[255:240]), 256'(16'h10C0));
    stride_r = 16'h0001;
`endif

    // randomized traffic: random contents, bases, start pulses and rare resets
    for (int it = 0; it < 25; it++) begin
      off = 16'($urandom);
      xr  = 16'($urandom);
`ifdef VLD_STRIDE_EN
      stride_r = 16'($urandom_range(0, 8));
`endif
      repeat ($urandom_range(40, 120)) begin
        start_r = ($urandom_range(0, 9) == 0);
        base_r  = 16'($urandom);
        rst_r   = ($urandom_range(0, 199) == 0);
        step();
      end
      start_r = 1'b0;
      rst_r   = 1'b0;
      drain(200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_load_unit.md
Name: vector_load_unit

Overview:
- Multi-cycle vector load engine between the SRAM and the vector register file write port.
- The control FSM pulses a start request with a 16-bit base address. The unit reads LANES consecutive 16-bit words from the single-port SRAM, one word at a time, into a 256-bit buffer.
- On completion it raises done for one cycle; the buffer then feeds the vector register write-data mux.

Parameters:
- LANES, 16, number of words gathered per load; vec_data width = LANES*WORD_W.
- WORD_W, 16, SRAM word width in bits.
- RD_LAT, 1, SRAM read latency in cycles from the mem_rd request cycle to mem_rdata valid; legal range 1..4.

Ports:
- clk2  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  load request; sampled only in IDLE.
- base_addr  input  16  word address of lane 0; latched when start is accepted.
- mem_rdata  input  WORD_W  SRAM read data.
- mem_addr  output  16  SRAM address during a request.
- mem_rd  output  1  SRAM read strobe, one cycle per lane.
- vec_data  output  LANES*WORD_W  assembled vector; lane i at bits [i*WORD_W +: WORD_W].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values (asserted at the rising edge while rst=1): state=IDLE, mem_rd=0, mem_addr=0, vec_data=0, busy=0, done=0, lane counter=0, wait counter=0.
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered or decoded from state.
- IDLE:
  - if start=1: latch base_addr into addr_reg, set lane=0, go to REQ.
  - else stay in IDLE.
- REQ: mem_rd=1, mem_addr=addr_reg; load wait counter with RD_LAT-1; go to WAIT.
- WAIT:
  - mem_rd=0; mem_addr holds its last value.
  - On the final WAIT cycle (counter=0): write mem_rdata into the lane slot of vec_data.
  - After that capture, if lane=LANES-1 go to DONE; otherwise lane+1, addr_reg+1, go to REQ.
  - Otherwise decrement the counter and stay in WAIT.
- DONE: done=1 for exactly this cycle, busy=1, then go to IDLE.
- Timing per lane: 1+RD_LAT cycles.
- Latency: start sampled in cycle 0 → done high in cycle 1+LANES*(1+RD_LAT), i.e. cycle 33 at default parameters.
- Address arithmetic: 16-bit modulo; 0xFFFF+1 wraps to 0x0000 with no flag.
- vec_data is updated lane by lane during a load and holds its final value after done until the next accepted start. Lanes not yet rewritten keep their old contents.
- Back-to-back loads:
  - start asserted while busy=1 is ignored; it is not queued.
  - start still high in the IDLE cycle after DONE begins a new load. The requester must drop start on seeing done.
- base_addr changes after acceptance have no effect on the current load.
- rst mid-load: abort at the next edge, all outputs return to reset values, no done pulse. Any SRAM read already in flight is discarded.
- mem_rdata is ignored in every cycle except the capture cycle.

Optional Feature:
- Macro: VLD_STRIDE_EN.
- Defined:
  - Adds input port stride, 16 bits, latched together with base_addr.
  - Lane address increment becomes addr_reg+stride, modulo 2^16.
  - stride=0 reads the same word into every lane.
- Undefined: no stride port; increment is fixed at 1.

Test Plan:
- Basic load: base_addr=0x0040; SRAM word at 0x0040+i holds 0x1000+i → done in cycle 33. vec_data lane i = 0x1000+i (lane 15 = 0x100F). Exactly 16 mem_rd pulses at addresses 0x0040..0x004F.
- Wrap-around: base_addr=0xFFF8 → addresses 0xFFF8..0xFFFF then 0x0000..0x0007. Lane 8 = contents of 0x0000.
- Busy-start ignore: a second start with base 0x0200 at cycle 10 → no effect, addresses continue from the first base, single done in cycle 33. start held high through DONE → second load begins, busy re-asserts the cycle after done.
- Reset mid-op: rst=1 in cycle 15 → next cycle vec_data=0, busy=0, mem_rd=0. No done pulse ever appears. A subsequent start completes normally.
- Latency parameter: RD_LAT=3, mem_rdata valid only in the third cycle after each mem_rd with garbage otherwise → correct lanes, done in cycle 65.
- VLD_STRIDE_EN defined, base=0x0100, stride=0x0004 → addresses 0x0100, 0x0104, …, 0x013C. With stride=0, all lanes equal the word at 0x0100.
